// File: rtl/uncache_write_buffer_pkg.sv
// Shared definitions for the uncached store buffer: AXI constants, the buffered
// store record and the drain state machine encoding.
package uncache_write_buffer_pkg;

    localparam logic [3:0] UNCACHE_WR_ID  = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_SEND,
        WB_RESP
    } wb_state_e;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/uncache_wbuf_fifo.sv
// Synchronous FIFO holding posted stores; count, full and empty are registered,
// so a pop never frees a slot for a push in the same cycle.
module uncache_wbuf_fifo
    import uncache_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  wbuf_entry_t din_i,
    input  logic        pop_i,
    output wbuf_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_COUNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uncache_write_buffer.sv
// Posts uncached CPU stores and drains them in order as single-beat AXI writes;
// the head entry is retired only on the B response so empty covers the in-flight store.
module uncache_write_buffer
    import uncache_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_addr,
    input  logic [3:0]  wr_wstrb,
    input  logic [31:0] wr_wdata,
    output logic        wr_addr_ok,
    output logic        wr_data_ok,
    output logic        empty,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    wbuf_entry_t push_entry, head;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    wb_state_e   state_q, state_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        data_ok_q;
    logic        aw_valid, w_valid, b_ready, sending;
    logic        unused_bchan;

    assign unused_bchan = ^{bid, bresp};

    assign push       = wr_req && !fifo_full;
    assign push_entry = '{addr: wr_addr, size: wr_size, wstrb: wr_wstrb, wdata: wr_wdata};

    uncache_wbuf_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .din_i  (push_entry),
        .pop_i  (pop),
        .head_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WB_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_ok_q <= push;
        end
    end

    // AW and W complete independently; the done flags include this cycle's handshakes
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (!fifo_empty) state_d = WB_SEND;
            end
            WB_SEND: begin
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if (aw_valid && awready) aw_done_d = 1'b1;
                if (w_valid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WB_RESP;
            end
            WB_RESP: begin
                b_ready = 1'b1;
                if (bvalid) begin
                    pop       = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    assign sending    = (state_q == WB_SEND);

    assign wr_addr_ok = !fifo_full;
    assign wr_data_ok = data_ok_q;
    assign empty      = fifo_empty;

    assign awid    = UNCACHE_WR_ID;
    assign awaddr  = sending ? head.addr : '0;
    assign awlen   = '0;
    assign awsize  = sending ? axi_size(head.size) : '0;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign awvalid = aw_valid;

    assign wid    = UNCACHE_WR_ID;
    assign wdata  = sending ? head.wdata : '0;
    assign wstrb  = sending ? head.wstrb : '0;
    assign wlast  = w_valid;
    assign wvalid = w_valid;
    assign bready = b_ready;

endmodule

// File: tb/tb_uncache_write_buffer.sv
// Directed bench for uncache_write_buffer: a queue model of posted stores is
// checked every cycle, plus literal timing expectations for each scenario.
module tb_uncache_write_buffer;

    logic        clk;
    logic        reset;
    logic        wr_req;
    logic [1:0]  wr_size;
    logic [31:0] wr_addr;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_wdata;
    logic        wr_addr_ok, wr_data_ok, empty;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    uncache_write_buffer #(
        .DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_size   (wr_size),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_wdata  (wr_wdata),
        .wr_addr_ok(wr_addr_ok),
        .wr_data_ok(wr_data_ok),
        .empty     (empty),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awlock    (awlock),
        .awcache   (awcache),
        .awprot    (awprot),
        .awvalid   (awvalid),
        .awready   (awready),
        .wid       (wid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } st_t;

    st_t         mq[$];
    logic [31:0] aw_log[$];
    logic        aw_seen, w_seen, dok_exp, aw_hold, w_hold;
    int unsigned w_beats;
    int unsigned n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted stores; checks sampled at negedge, then advanced
    // by the transfers the next rising edge will perform.
    initial begin : compare
        logic acc;
        aw_seen = 1'b0; w_seen = 1'b0; dok_exp = 1'b0;
        aw_hold = 1'b0; w_hold = 1'b0; w_beats = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                aw_seen = 1'b0; w_seen = 1'b0; dok_exp = 1'b0;
                aw_hold = 1'b0; w_hold = 1'b0;
            end else begin
                chk("wr_addr_ok", 32'(wr_addr_ok), 32'(mq.size() < 4));
                chk("empty", 32'(empty), 32'(mq.size() == 0));
                chk("wr_data_ok", 32'(wr_data_ok), 32'(dok_exp));
                chk("bready", 32'(bready), 32'(aw_seen && w_seen));
                chk("awvalid_legal", 32'(awvalid && (mq.size() == 0 || aw_seen)), 32'(0));
                chk("wvalid_legal", 32'(wvalid && (mq.size() == 0 || w_seen)), 32'(0));
                chk("awvalid_held", 32'(aw_hold && !awvalid), 32'(0));
                chk("wvalid_held", 32'(w_hold && !wvalid), 32'(0));
                chk("wlast", 32'(wlast), 32'(wvalid));
                chk("fixed_fields", {awid, wid, awlen, awburst, awlock, awcache, awprot, 5'd0},
                    {4'd1, 4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 5'd0});
                if (awvalid && mq.size() != 0) begin
                    chk("awaddr", awaddr, mq[0].addr);
                    chk("awsize", 32'(awsize), 32'({1'b0, mq[0].size}));
                end
                if (wvalid && mq.size() != 0) begin
                    chk("wdata", wdata, mq[0].data);
                    chk("wstrb", 32'(wstrb), 32'(mq[0].strb));
                end

                acc = wr_req && (mq.size() < 4);
                if (awvalid && awready) begin
                    aw_seen = 1'b1;
                    aw_log.push_back(awaddr);
                end
                if (wvalid && wready) begin
                    w_seen = 1'b1;
                    w_beats++;
                end
                aw_hold = awvalid && !awready;
                w_hold  = wvalid && !wready;
                if (bready && bvalid) begin
                    if (mq.size() != 0) void'(mq.pop_front());
                    aw_seen = 1'b0;
                    w_seen  = 1'b0;
                end
                if (acc) mq.push_back('{addr: wr_addr, size: wr_size, strb: wr_wstrb, data: wr_wdata});
                dok_exp = acc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [1:0] s, input logic [3:0] st, input logic [31:0] d);
        wr_req = 1'b1; wr_addr = a; wr_size = s; wr_wstrb = st; wr_wdata = d;
    endtask

    task automatic wait_empty(input string name);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!empty && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(empty), 32'(1));
    endtask

    task automatic wait_bready(input string name);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!bready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(bready), 32'(1));
    endtask

    initial begin : stimulus
        int unsigned k;
        int unsigned w0;
        n_vec = 0; n_err = 0;
        reset = 1'b1; wr_req = 1'b0; wr_size = '0; wr_addr = '0; wr_wstrb = '0; wr_wdata = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_addr_ok", 32'(wr_addr_ok), 32'(1));
        chk("rst_data_ok", 32'(wr_data_ok), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        chk("rst_wlast", 32'(wlast), 32'(0));
        chk("rst_awaddr", awaddr, 32'd0);

        // Single word store, all ready
        cyc(); req(32'h1FD0_F000, 2'd2, 4'hF, 32'hDEAD_BEEF);
        cyc(); wr_req = 1'b0;
        @(negedge clk);
        chk("t1_dok_T1", 32'(wr_data_ok), 32'(1));
        chk("t1_notempty_T1", 32'(empty), 32'(0));
        chk("t1_aw_T1", 32'(awvalid), 32'(0));
        @(negedge clk);
        chk("t1_aw_T2", {30'd0, awvalid, wvalid}, 32'd3);
        chk("t1_awsize", 32'(awsize), 32'd2);
        chk("t1_awaddr", awaddr, 32'h1FD0_F000);
        chk("t1_wdata", wdata, 32'hDEAD_BEEF);
        chk("t1_dok_T2", 32'(wr_data_ok), 32'(0));
        @(negedge clk);
        chk("t1_bready_T3", 32'(bready), 32'(1));
        chk("t1_aw_T3", 32'(awvalid), 32'(0));
        @(negedge clk);
        chk("t1_empty_T4", 32'(empty), 32'(1));
        chk("t1_bready_T4", 32'(bready), 32'(0));

        // Fill four with AW stalled, fifth held until a B retires
        aw_log.delete();
        awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); req(32'h1000_0000 + 32'(i * 4), 2'd2, 4'hF, 32'hA000_0000 + 32'(i));
        end
        cyc(); req(32'h1000_0010, 2'd2, 4'hF, 32'hA000_0004);
        @(negedge clk);
        chk("t2_full", 32'(wr_addr_ok), 32'(0));
        repeat (2) begin
            @(negedge clk);
            chk("t2_held", 32'(wr_addr_ok), 32'(0));
        end
        cyc(); awready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!wr_addr_ok && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t2_room", 32'(wr_addr_ok), 32'(1));
        cyc(); wr_req = 1'b0;
        wait_empty("t2_drain");
        chk("t2_aw_count", 32'(aw_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("t2_aw_order", (i < aw_log.size()) ? aw_log[i] : 32'hFFFF_FFFF, 32'h1000_0000 + 32'(i * 4));

        // W accepted before AW
        w0 = w_beats;
        awready = 1'b0;
        cyc(); req(32'h1FD0_F100, 2'd2, 4'hF, 32'h1234_5678);
        cyc(); wr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_T2", {30'd0, awvalid, wvalid}, 32'd3);
        repeat (2) begin
            @(negedge clk);
            chk("t3_wait", {29'd0, awvalid, wvalid, bready}, 32'b100);
        end
        cyc(); awready = 1'b1;
        @(negedge clk);
        chk("t3_T5", {29'd0, awvalid, wvalid, bready}, 32'b100);
        @(negedge clk);
        chk("t3_T6", {29'd0, awvalid, wvalid, bready}, 32'b001);
        wait_empty("t3_drain");
        chk("t3_wbeats", 32'(w_beats - w0), 32'd1);

        // Byte store at offset 3
        cyc(); req(32'h1FD0_F003, 2'd0, 4'b1000, 32'hAB00_0000);
        cyc(); wr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_awvalid", 32'(awvalid), 32'(1));
        chk("t4_awsize", 32'(awsize), 32'd0);
        chk("t4_awaddr", awaddr, 32'h1FD0_F003);
        chk("t4_wstrb", 32'(wstrb), 32'b1000);
        wait_empty("t4_drain");

        // Push coincident with the B pop, two entries queued
        aw_log.delete();
        bvalid = 1'b0;
        cyc(); req(32'h2000_0000, 2'd2, 4'hF, 32'h1111_1111);
        cyc(); req(32'h2000_0004, 2'd2, 4'hF, 32'h2222_2222);
        cyc(); wr_req = 1'b0;
        wait_bready("t5_resp");
        cyc(); bvalid = 1'b1; req(32'h2000_0008, 2'd1, 4'b0011, 32'h0000_3333);
        cyc(); wr_req = 1'b0; bvalid = 1'b0;
        @(negedge clk);
        chk("t5_dok", 32'(wr_data_ok), 32'(1));
        chk("t5_bready", 32'(bready), 32'(0));
        chk("t5_notempty", 32'(empty), 32'(0));
        k = 0;
        while (!awvalid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t5_awvalid", 32'(awvalid), 32'(1));
        chk("t5_awaddr", awaddr, 32'h2000_0004);
        cyc(); bvalid = 1'b1;
        wait_empty("t5_drain");
        chk("t5_aw_last", (aw_log.size() == 3) ? aw_log[2] : 32'hFFFF_FFFF, 32'h2000_0008);

        // Reset while waiting on B with three entries
        bvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); req(32'h3000_0000 + 32'(i * 4), 2'd2, 4'hF, 32'h5000_0000 + 32'(i));
        end
        cyc(); wr_req = 1'b0;
        wait_bready("t6_resp");
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        @(negedge clk);
        chk("t6_empty", 32'(empty), 32'(1));
        chk("t6_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        chk("t6_addr_ok", 32'(wr_addr_ok), 32'(1));
        bvalid = 1'b1;
        cyc(); req(32'h3000_0100, 2'd2, 4'hF, 32'hC0DE_0001);
        cyc(); wr_req = 1'b0;
        wait_empty("t6_recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
